// File: rtl/dm_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_wb_pkg
// Brief    : Shared state encodings and parameter checks for dm_wb_bridge.
// Revision : 1.0 - initial release
// ============================================================================
package dm_wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } slv_state_e;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_BUS  = 2'd1,
        M_RESP = 2'd2
    } mst_state_e;

    function automatic bit bus_width_ok(input int width);
        return (width == 32) || (width == 64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_wb_if
// Brief    : Bus bundle between the SoC / dm_top and the Wishbone bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_wb_if #(
    parameter int BUS_WIDTH = 32
);
    logic [BUS_WIDTH-1:0]   wb_s_adr_i;
    logic [BUS_WIDTH-1:0]   wb_s_dat_i;
    logic [BUS_WIDTH/8-1:0] wb_s_sel_i;
    logic                   wb_s_we_i;
    logic                   wb_s_cyc_i;
    logic                   wb_s_stb_i;
    logic [BUS_WIDTH-1:0]   wb_s_dat_o;
    logic                   wb_s_ack_o;
    logic                   wb_s_err_o;

    logic                   dm_s_req_o;
    logic                   dm_s_we_o;
    logic [BUS_WIDTH-1:0]   dm_s_addr_o;
    logic [BUS_WIDTH/8-1:0] dm_s_be_o;
    logic [BUS_WIDTH-1:0]   dm_s_wdata_o;
    logic [BUS_WIDTH-1:0]   dm_s_rdata_i;

    logic                   dm_m_req_i;
    logic [BUS_WIDTH-1:0]   dm_m_add_i;
    logic                   dm_m_we_i;
    logic [BUS_WIDTH-1:0]   dm_m_wdata_i;
    logic [BUS_WIDTH/8-1:0] dm_m_be_i;
    logic                   dm_m_gnt_o;
    logic                   dm_m_r_valid_o;
    logic [BUS_WIDTH-1:0]   dm_m_r_rdata_o;
    logic                   dm_m_r_err_o;

    logic [BUS_WIDTH-1:0]   wb_m_adr_o;
    logic [BUS_WIDTH-1:0]   wb_m_dat_o;
    logic [BUS_WIDTH/8-1:0] wb_m_sel_o;
    logic                   wb_m_we_o;
    logic                   wb_m_cyc_o;
    logic                   wb_m_stb_o;
    logic [BUS_WIDTH-1:0]   wb_m_dat_i;
    logic                   wb_m_ack_i;
    logic                   wb_m_err_i;
    logic                   timeout_o;

    // Bridge view
    modport slave (
        input  wb_s_adr_i, wb_s_dat_i, wb_s_sel_i, wb_s_we_i, wb_s_cyc_i, wb_s_stb_i,
        output wb_s_dat_o, wb_s_ack_o, wb_s_err_o,
        output dm_s_req_o, dm_s_we_o, dm_s_addr_o, dm_s_be_o, dm_s_wdata_o,
        input  dm_s_rdata_i,
        input  dm_m_req_i, dm_m_add_i, dm_m_we_i, dm_m_wdata_i, dm_m_be_i,
        output dm_m_gnt_o, dm_m_r_valid_o, dm_m_r_rdata_o, dm_m_r_err_o,
        output wb_m_adr_o, wb_m_dat_o, wb_m_sel_o, wb_m_we_o, wb_m_cyc_o, wb_m_stb_o,
        input  wb_m_dat_i, wb_m_ack_i, wb_m_err_i,
        output timeout_o
    );

    // Environment view (interconnect, dm_top and downstream Wishbone slave)
    modport master (
        output wb_s_adr_i, wb_s_dat_i, wb_s_sel_i, wb_s_we_i, wb_s_cyc_i, wb_s_stb_i,
        input  wb_s_dat_o, wb_s_ack_o, wb_s_err_o,
        input  dm_s_req_o, dm_s_we_o, dm_s_addr_o, dm_s_be_o, dm_s_wdata_o,
        output dm_s_rdata_i,
        output dm_m_req_i, dm_m_add_i, dm_m_we_i, dm_m_wdata_i, dm_m_be_i,
        input  dm_m_gnt_o, dm_m_r_valid_o, dm_m_r_rdata_o, dm_m_r_err_o,
        input  wb_m_adr_o, wb_m_dat_o, wb_m_sel_o, wb_m_we_o, wb_m_cyc_o, wb_m_stb_o,
        output wb_m_dat_i, wb_m_ack_i, wb_m_err_i,
        input  timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/dm_wb_sba_master.sv
`default_nettype none
// ============================================================================
// Module   : dm_wb_sba_master
// Brief    : dm_top system-bus master to Wishbone master, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module dm_wb_sba_master
    import dm_wb_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int MST_TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   dm_m_req_i,
    input  logic [BUS_WIDTH-1:0]   dm_m_add_i,
    input  logic                   dm_m_we_i,
    input  logic [BUS_WIDTH-1:0]   dm_m_wdata_i,
    input  logic [BUS_WIDTH/8-1:0] dm_m_be_i,
    output logic                   dm_m_gnt_o,
    output logic                   dm_m_r_valid_o,
    output logic [BUS_WIDTH-1:0]   dm_m_r_rdata_o,
    output logic                   dm_m_r_err_o,
    output logic [BUS_WIDTH-1:0]   wb_m_adr_o,
    output logic [BUS_WIDTH-1:0]   wb_m_dat_o,
    output logic [BUS_WIDTH/8-1:0] wb_m_sel_o,
    output logic                   wb_m_we_o,
    output logic                   wb_m_cyc_o,
    output logic                   wb_m_stb_o,
    input  logic [BUS_WIDTH-1:0]   wb_m_dat_i,
    input  logic                   wb_m_ack_i,
    input  logic                   wb_m_err_i,
    output logic                   timeout_o
);

    localparam int c_CNT_W = (MST_TIMEOUT > 0) ? $clog2(MST_TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO = c_CNT_W'(MST_TIMEOUT);
    localparam bit c_TMO_EN = (MST_TIMEOUT != 0);

    mst_state_e             r_state;
    mst_state_e             w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [BUS_WIDTH-1:0]   r_adr;
    logic [BUS_WIDTH-1:0]   r_wdat;
    logic [BUS_WIDTH/8-1:0] r_sel;
    logic                   r_we;
    logic [BUS_WIDTH-1:0]   r_rdata;
    logic                   r_rerr;
    logic                   r_tmo;
    logic                   w_gnt;
    logic                   w_tmo_hit;
    logic                   w_term;

    assign w_tmo_hit = c_TMO_EN && (r_cnt == c_TMO);
    assign w_term    = wb_m_ack_i || wb_m_err_i || w_tmo_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= M_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        case (r_state)
            M_IDLE: begin
                w_gnt = dm_m_req_i && !rst_i;
                if (w_gnt) begin
                    w_state_nxt = M_BUS;
                end
            end
            M_BUS: begin
                if (w_term) begin
                    w_state_nxt = M_RESP;
                end
            end
            M_RESP:  w_state_nxt = M_IDLE;
            default: w_state_nxt = M_IDLE;
        endcase
    end

    // Error beats ack, ack beats a timeout landing in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_rerr  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_adr  <= dm_m_add_i;
                r_wdat <= dm_m_wdata_i;
                r_sel  <= dm_m_be_i;
                r_we   <= dm_m_we_i;
                r_cnt  <= '0;
            end
            if (r_state == M_BUS) begin
                r_cnt <= r_cnt + 1'b1;
                if (wb_m_err_i) begin
                    r_rerr  <= 1'b1;
                    r_rdata <= '0;
                    r_tmo   <= 1'b0;
                end else if (wb_m_ack_i) begin
                    r_rerr  <= 1'b0;
                    r_rdata <= r_we ? '0 : wb_m_dat_i;
                    r_tmo   <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_rerr  <= 1'b1;
                    r_rdata <= '0;
                    r_tmo   <= 1'b1;
                end
            end
        end
    end

    assign dm_m_gnt_o     = w_gnt;
    assign dm_m_r_valid_o = (r_state == M_RESP);
    assign dm_m_r_rdata_o = dm_m_r_valid_o ? r_rdata : '0;
    assign dm_m_r_err_o   = dm_m_r_valid_o && r_rerr;
    assign timeout_o      = dm_m_r_valid_o && r_tmo;
    assign wb_m_cyc_o     = (r_state == M_BUS);
    assign wb_m_stb_o     = (r_state == M_BUS);
    assign wb_m_adr_o     = r_adr;
    assign wb_m_dat_o     = r_wdat;
    assign wb_m_sel_o     = r_sel;
    assign wb_m_we_o      = r_we;

endmodule
`default_nettype wire

// File: rtl/dm_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dm_wb_bridge
// Brief    : Wishbone adapter for the debug module slave and system-bus ports.
// Revision : 1.0 - initial release
// ============================================================================
module dm_wb_bridge
    import dm_wb_pkg::*;
#(
    parameter int          BUS_WIDTH       = 32,
    parameter logic [63:0] DM_BASE_ADDRESS = 64'h0000_0000_0000_1000,
    parameter logic [63:0] DM_ADDR_MASK    = 64'hFFFF_FFFF_FFFF_F000,
    parameter int          SLV_LATENCY     = 1,
    parameter int          MST_TIMEOUT     = 255
) (
    input  logic    clk_i,
    input  logic    rst_i,
    dm_wb_if.slave  bus
);

    localparam logic [BUS_WIDTH-1:0] c_BASE = DM_BASE_ADDRESS[BUS_WIDTH-1:0];
    localparam logic [BUS_WIDTH-1:0] c_MASK = DM_ADDR_MASK[BUS_WIDTH-1:0];
    localparam logic [2:0]           c_LAT  = 3'(SLV_LATENCY);

    generate
        if (!bus_width_ok(BUS_WIDTH) || SLV_LATENCY < 1 || SLV_LATENCY > 4) begin : g_bad_params
            $error("dm_wb_bridge: BUS_WIDTH must be 32/64 and SLV_LATENCY 1..4");
        end
    endgenerate

    slv_state_e             r_state;
    slv_state_e             w_state_nxt;
    logic [2:0]             r_lat_cnt;
    logic                   r_abort;
    logic                   r_err;
    logic                   r_we;
    logic [BUS_WIDTH-1:0]   r_adr;
    logic [BUS_WIDTH-1:0]   r_wdat;
    logic [BUS_WIDTH-1:0]   r_rdat;
    logic [BUS_WIDTH/8-1:0] r_sel;
    logic                   w_req_seen;
    logic                   w_hit;
    logic                   w_accept;
    logic                   w_lat_done;
    logic                   w_ack;
    logic                   w_dm_req;

    // The error cycle blocks acceptance so back-to-back requests see a gap
    assign w_req_seen = bus.wb_s_cyc_i && bus.wb_s_stb_i && !r_err;
    assign w_hit      = ((bus.wb_s_adr_i & c_MASK) == c_BASE);
    assign w_accept   = (r_state == S_IDLE) && w_req_seen && w_hit;
    assign w_lat_done = (r_lat_cnt == c_LAT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_dm_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_dm_req = (r_lat_cnt == 3'd0);
                if (w_lat_done) begin
                    w_state_nxt = (bus.wb_s_cyc_i && !r_abort) ? S_ACK : S_IDLE;
                end
            end
            S_ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lat_cnt <= '0;
            r_abort   <= 1'b0;
            r_err     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_rdat    <= '0;
            r_sel     <= '0;
        end else begin
            r_err <= (r_state == S_IDLE) && w_req_seen && !w_hit;
            if (w_accept) begin
                r_adr     <= bus.wb_s_adr_i;
                r_wdat    <= bus.wb_s_dat_i;
                r_sel     <= bus.wb_s_sel_i;
                r_we      <= bus.wb_s_we_i;
                r_lat_cnt <= '0;
                r_abort   <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                if (!bus.wb_s_cyc_i) begin
                    r_abort <= 1'b1;
                end
                if (w_lat_done) begin
                    r_rdat <= r_we ? '0 : bus.dm_s_rdata_i;
                end else begin
                    r_lat_cnt <= r_lat_cnt + 3'd1;
                end
            end
        end
    end

    assign bus.wb_s_ack_o   = w_ack;
    assign bus.wb_s_err_o   = r_err;
    assign bus.wb_s_dat_o   = r_rdat;
    assign bus.dm_s_req_o   = w_dm_req;
    assign bus.dm_s_we_o    = r_we;
    assign bus.dm_s_addr_o  = r_adr;
    assign bus.dm_s_be_o    = r_sel;
    assign bus.dm_s_wdata_o = r_wdat;

    dm_wb_sba_master #(
        .BUS_WIDTH   (BUS_WIDTH),
        .MST_TIMEOUT (MST_TIMEOUT)
    ) u_sba_master (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .dm_m_req_i     (bus.dm_m_req_i),
        .dm_m_add_i     (bus.dm_m_add_i),
        .dm_m_we_i      (bus.dm_m_we_i),
        .dm_m_wdata_i   (bus.dm_m_wdata_i),
        .dm_m_be_i      (bus.dm_m_be_i),
        .dm_m_gnt_o     (bus.dm_m_gnt_o),
        .dm_m_r_valid_o (bus.dm_m_r_valid_o),
        .dm_m_r_rdata_o (bus.dm_m_r_rdata_o),
        .dm_m_r_err_o   (bus.dm_m_r_err_o),
        .wb_m_adr_o     (bus.wb_m_adr_o),
        .wb_m_dat_o     (bus.wb_m_dat_o),
        .wb_m_sel_o     (bus.wb_m_sel_o),
        .wb_m_we_o      (bus.wb_m_we_o),
        .wb_m_cyc_o     (bus.wb_m_cyc_o),
        .wb_m_stb_o     (bus.wb_m_stb_o),
        .wb_m_dat_i     (bus.wb_m_dat_i),
        .wb_m_ack_i     (bus.wb_m_ack_i),
        .wb_m_err_i     (bus.wb_m_err_i),
        .timeout_o      (bus.timeout_o)
    );

endmodule
`default_nettype wire
